wvb_readout_ctrl: RTL and testbench

Readout sequencer for the waveform buffer storage block (32K x 28 sample RAM plus 87-bit header FIFO).
- Pops one header at a time and extracts the waveform's start and stop RAM addresses.
- Drives the RAM read address across that range, wrapping modulo 2^P_ADR_WIDTH.
- Delivers header and samples downstream on a valid/ready stream with sop/eop framing.
- Publishes a "done" pointer so the write side can compute free space.

---
 rtl/wvb_pkg.sv | 19 +
 rtl/wvb_rd_skid_fifo.sv | 71 +++++++
 rtl/wvb_readout_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_wvb_readout_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wvb_pkg.sv
// Shared definitions for the waveform buffer readout path: header field
// placement, readout FSM encoding and the end-of-event flag position.
package wvb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HDR_WAIT = 2'd1,
        ST_STREAM   = 2'd2
    } wvb_state_e;

    localparam int HDR_STOP_LSB = 0;
    localparam int EOE_BIT      = 0;

    // The start address sits directly above the stop address in the header.
    function automatic int hdr_start_lsb(input int adr_width);
        return HDR_STOP_LSB + adr_width;
    endfunction

endpackage

// File: rtl/wvb_rd_skid_fifo.sv
// Small skid FIFO that absorbs RAM read data still in flight when the
// downstream stream stalls.
module wvb_rd_skid_fifo #(
    parameter int P_DEPTH = 2,
    parameter int P_WIDTH = 30,
    parameter int P_CNT_W = $clog2(P_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic [P_WIDTH-1:0] wr_data_i,
    input  logic               pop_i,
    output logic [P_WIDTH-1:0] rd_data_o,
    output logic [P_CNT_W-1:0] count_o,
    output logic               empty_o
);

    localparam int PTR_W = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;

    logic [P_WIDTH-1:0] mem_q [P_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [P_CNT_W-1:0] count_q;
    logic               pop_ok_s;
    logic               push_ok_s;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(P_DEPTH - 1)) begin
            return PTR_W'(0);
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Qualify push/pop against occupancy
    always_comb begin
        pop_ok_s  = pop_i && (count_q != P_CNT_W'(0));
        push_ok_s = push_i && ((count_q != P_CNT_W'(P_DEPTH)) || pop_ok_s);
    end

    // Storage, pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < P_DEPTH; i++) begin
                mem_q[i] <= P_WIDTH'(0);
            end
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= P_CNT_W'(0);
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + P_CNT_W'(1);
                2'b01:   count_q <= count_q - P_CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign empty_o   = (count_q == P_CNT_W'(0));

endmodule

// File: rtl/wvb_readout_ctrl.sv
// Readout sequencer: pops a header, reads its sample range out of the
// waveform RAM (wrapping) and streams it with sop/eop framing.
module wvb_readout_ctrl
    import wvb_pkg::*;
#(
    parameter int P_DATA_WIDTH = 28,
    parameter int P_ADR_WIDTH  = 15,
    parameter int P_HDR_WIDTH  = 87,
    parameter int P_RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    input  logic                    hdr_empty_i,
    output logic                    hdr_rdreq_o,
    input  logic [P_HDR_WIDTH-1:0]  hdr_data_i,
    output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr_o,
    input  logic [P_DATA_WIDTH-1:0] wvb_data_i,
    output logic [P_HDR_WIDTH-1:0]  out_hdr_o,
    output logic [P_DATA_WIDTH-1:0] out_data_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    out_sop_o,
    output logic                    out_eop_o,
    output logic [P_ADR_WIDTH-1:0]  done_ptr_o,
    output logic                    busy_o,
    output logic                    err_eoe_o
);

    localparam int DEPTH     = P_RD_LATENCY + 1;
    localparam int FW        = P_DATA_WIDTH + 2;
    localparam int CNT_W     = $clog2(DEPTH + 1);
    localparam int LEN_W     = P_ADR_WIDTH + 1;
    localparam int START_LSB = hdr_start_lsb(P_ADR_WIDTH);

    wvb_state_e             state_q, state_d;
    logic [P_ADR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]       remain_q, remain_d;
    logic                   first_q, first_d;
    logic [P_ADR_WIDTH-1:0] stop_q, stop_d;
    logic [P_HDR_WIDTH-1:0] hdr_q, hdr_d;
    logic [P_ADR_WIDTH-1:0] done_ptr_q;
    logic                   err_eoe_q;

    logic [P_RD_LATENCY-1:0] pipe_vld_q;
    logic [P_RD_LATENCY-1:0] pipe_sop_q;
    logic [P_RD_LATENCY-1:0] pipe_eop_q;

    logic                    hdr_rdreq_s;
    logic                    issue_s;
    logic                    accept_s;
    logic [CNT_W-1:0]        in_flight_s;
    logic [CNT_W-1:0]        occ_after_s;
    logic [P_ADR_WIDTH-1:0]  hdr_start_s;
    logic [P_ADR_WIDTH-1:0]  hdr_stop_s;

    logic [FW-1:0]           fifo_wr_s;
    logic [FW-1:0]           fifo_rd_s;
    logic [CNT_W-1:0]        fifo_count_s;
    logic                    fifo_empty_s;
    logic                    fifo_sop_s;
    logic                    fifo_eop_s;
    logic [P_DATA_WIDTH-1:0] fifo_data_s;

    assign hdr_start_s = hdr_data_i[START_LSB +: P_ADR_WIDTH];
    assign hdr_stop_s  = hdr_data_i[HDR_STOP_LSB +: P_ADR_WIDTH];

    assign {fifo_sop_s, fifo_eop_s, fifo_data_s} = fifo_rd_s;
    assign accept_s = !fifo_empty_s && out_ready_i;

    // Reads still in the RAM pipe or parked in the skid FIFO; a new read is
    // only issued when its slot is guaranteed, counting this cycle's accept.
    always_comb begin
        in_flight_s = fifo_count_s;
        for (int i = 0; i < P_RD_LATENCY; i++) begin
            in_flight_s = in_flight_s + CNT_W'(pipe_vld_q[i]);
        end
        occ_after_s = in_flight_s - CNT_W'(accept_s);
        issue_s     = (state_q == ST_STREAM) && (remain_q != LEN_W'(0)) &&
                      (occ_after_s < CNT_W'(DEPTH));
    end

    // Next-state logic for the readout sequencer
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        remain_d    = remain_q;
        first_d     = first_q;
        stop_d      = stop_q;
        hdr_d       = hdr_q;
        hdr_rdreq_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_i && !hdr_empty_i) begin
                    hdr_rdreq_s = 1'b1;
                    state_d     = ST_HDR_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR_WAIT: begin
                hdr_d    = hdr_data_i;
                stop_d   = hdr_stop_s;
                rd_ptr_d = hdr_start_s;
                // Modular distance plus one: 1..2^P_ADR_WIDTH samples.
                remain_d = {1'b0, hdr_stop_s - hdr_start_s} + LEN_W'(1);
                first_d  = 1'b1;
                state_d  = ST_STREAM;
            end
            ST_STREAM: begin
                if (issue_s) begin
                    rd_ptr_d = rd_ptr_q + P_ADR_WIDTH'(1);
                    remain_d = remain_q - LEN_W'(1);
                    first_d  = 1'b0;
                end else begin
                    rd_ptr_d = rd_ptr_q;
                end
                if (accept_s && fifo_eop_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STREAM;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and current waveform context
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rd_ptr_q <= P_ADR_WIDTH'(0);
            remain_q <= LEN_W'(0);
            first_q  <= 1'b0;
            stop_q   <= P_ADR_WIDTH'(0);
            hdr_q    <= P_HDR_WIDTH'(0);
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            remain_q <= remain_d;
            first_q  <= first_d;
            stop_q   <= stop_d;
            hdr_q    <= hdr_d;
        end
    end

    // Framing tags travel alongside the RAM read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q <= P_RD_LATENCY'(0);
            pipe_sop_q <= P_RD_LATENCY'(0);
            pipe_eop_q <= P_RD_LATENCY'(0);
        end else begin
            pipe_vld_q[0] <= issue_s;
            pipe_sop_q[0] <= issue_s && first_q;
            pipe_eop_q[0] <= issue_s && (remain_q == LEN_W'(1));
            for (int i = 1; i < P_RD_LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_sop_q[i] <= pipe_sop_q[i-1];
                pipe_eop_q[i] <= pipe_eop_q[i-1];
            end
        end
    end

    assign fifo_wr_s = {pipe_sop_q[P_RD_LATENCY-1], pipe_eop_q[P_RD_LATENCY-1], wvb_data_i};

    wvb_rd_skid_fifo #(
        .P_DEPTH (DEPTH),
        .P_WIDTH (FW),
        .P_CNT_W (CNT_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (pipe_vld_q[P_RD_LATENCY-1]),
        .wr_data_i (fifo_wr_s),
        .pop_i     (accept_s),
        .rd_data_o (fifo_rd_s),
        .count_o   (fifo_count_s),
        .empty_o   (fifo_empty_s)
    );

    // Free-space pointer for the writer and sticky eoe consistency flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_ptr_q <= P_ADR_WIDTH'(0);
            err_eoe_q  <= 1'b0;
        end else begin
            if (accept_s && fifo_eop_s) begin
                done_ptr_q <= stop_q + P_ADR_WIDTH'(1);
            end
            if (accept_s && (fifo_data_s[EOE_BIT] != fifo_eop_s)) begin
                err_eoe_q <= 1'b1;
            end
        end
    end

    assign hdr_rdreq_o   = hdr_rdreq_s;
    assign wvb_rd_addr_o = rd_ptr_q;
    assign out_hdr_o     = hdr_q;
    assign out_data_o    = fifo_data_s;
    assign out_valid_o   = !fifo_empty_s;
    assign out_sop_o     = fifo_sop_s;
    assign out_eop_o     = fifo_eop_s;
    assign done_ptr_o    = done_ptr_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign err_eoe_o     = err_eoe_q;

endmodule

// File: tb/tb_wvb_readout_ctrl.sv
// Bench for wvb_readout_ctrl: header FIFO and RAM models, a queue-based
// expected-sample model checked every cycle, and directed scenarios.
module tb_wvb_readout_ctrl;

    localparam int DW  = 28;
    localparam int AW  = 15;
    localparam int HW  = 87;
    localparam int LAT = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en_i = 1'b0;
    logic          hdr_empty_i;
    logic          hdr_rdreq_o;
    logic [HW-1:0] hdr_data_i = '0;
    logic [AW-1:0] wvb_rd_addr_o;
    logic [DW-1:0] wvb_data_i;
    logic [HW-1:0] out_hdr_o;
    logic [DW-1:0] out_data_o;
    logic          out_valid_o;
    logic          out_ready_i = 1'b1;
    logic          out_sop_o;
    logic          out_eop_o;
    logic [AW-1:0] done_ptr_o;
    logic          busy_o;
    logic          err_eoe_o;

    wvb_readout_ctrl #(
        .P_DATA_WIDTH (DW),
        .P_ADR_WIDTH  (AW),
        .P_HDR_WIDTH  (HW),
        .P_RD_LATENCY (LAT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en_i          (en_i),
        .hdr_empty_i   (hdr_empty_i),
        .hdr_rdreq_o   (hdr_rdreq_o),
        .hdr_data_i    (hdr_data_i),
        .wvb_rd_addr_o (wvb_rd_addr_o),
        .wvb_data_i    (wvb_data_i),
        .out_hdr_o     (out_hdr_o),
        .out_data_o    (out_data_o),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_sop_o     (out_sop_o),
        .out_eop_o     (out_eop_o),
        .done_ptr_o    (done_ptr_o),
        .busy_o        (busy_o),
        .err_eoe_o     (err_eoe_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [HW-1:0] hdr;
        logic [AW-1:0] stop;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          ce;
    logic [HW-1:0] hq[$];
    logic [DW-1:0] log_q[$];
    int            n_pushed = 0;
    int            n_popped = 0;
    int            n_chk = 0;
    int            n_fail = 0;

    assign hdr_empty_i = (n_pushed == n_popped);

    // Header FIFO: dout valid the cycle after the pop request.
    always @(posedge clk) begin
        if (hdr_rdreq_o && (n_popped < n_pushed)) begin
            hdr_data_i <= hq.pop_front();
            n_popped   <= n_popped + 1;
        end
    end

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe [LAT];

    // RAM with LAT cycles from address to data.
    always @(posedge clk) begin
        rd_pipe[0] <= mem[wvb_rd_addr_o];
        for (int i = 1; i < LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign wvb_data_i = rd_pipe[LAT-1];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Model state
    logic          model_busy = 1'b0;
    logic [AW-1:0] model_done = '0;
    logic          model_err = 1'b0;
    logic          in_wave = 1'b0;
    logic          chk_bubble = 1'b1;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_sop = 1'b0;
    logic          prev_eop = 1'b0;
    logic          waiting_first = 1'b0;
    logic          exp_rdreq;
    int            cyc = 0;
    int            pop_cyc = 0;
    int            n_acc = 0;
    int            n_sop = 0;
    int            n_eop = 0;

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            model_busy    = 1'b0;
            model_done    = '0;
            model_err     = 1'b0;
            in_wave       = 1'b0;
            prev_stall    = 1'b0;
            waiting_first = 1'b0;
        end else begin
            exp_rdreq = !model_busy && en_i && !hdr_empty_i;
            chk("hdr_rdreq", 128'(hdr_rdreq_o), 128'(exp_rdreq));
            chk("busy", 128'(busy_o), 128'(model_busy));
            chk("done_ptr", 128'(done_ptr_o), 128'(model_done));
            chk("err_eoe", 128'(err_eoe_o), 128'(model_err));
            if (prev_stall) begin
                chk("stall_valid", 128'(out_valid_o), 128'(1));
                chk("stall_data", 128'(out_data_o), 128'(prev_data));
                chk("stall_sop", 128'(out_sop_o), 128'(prev_sop));
                chk("stall_eop", 128'(out_eop_o), 128'(prev_eop));
            end
            if (in_wave && chk_bubble) begin
                chk("no_bubble", 128'(out_valid_o), 128'(1));
            end
            if (out_valid_o && waiting_first) begin
                chk("first_latency", 128'(cyc - pop_cyc), 128'(3 + LAT));
                waiting_first = 1'b0;
            end
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_sample: got data %0h expected no sample", out_data_o);
                end else begin
                    ce = exp_q.pop_front();
                    chk("out_data", 128'(out_data_o), 128'(ce.data));
                    chk("out_sop", 128'(out_sop_o), 128'(ce.sop));
                    chk("out_eop", 128'(out_eop_o), 128'(ce.eop));
                    chk("out_hdr", 128'(out_hdr_o), 128'(ce.hdr));
                    n_acc++;
                    if (ce.sop) n_sop++;
                    if (ce.eop) n_eop++;
                    log_q.push_back(out_data_o);
                    in_wave = !ce.eop;
                    if (ce.eop) begin
                        model_done = ce.stop + 15'd1;
                        model_busy = 1'b0;
                    end
                    if (ce.data[0] != ce.eop) model_err = 1'b1;
                end
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_data  = out_data_o;
            prev_sop   = out_sop_o;
            prev_eop   = out_eop_o;
            if (exp_rdreq) begin
                model_busy    = 1'b1;
                pop_cyc       = cyc;
                waiting_first = 1'b1;
            end
        end
    end

    // Queue a header and its expected samples; RAM content encodes id/addr/eoe.
    task automatic enq(input logic [AW-1:0] start, input logic [AW-1:0] stop,
                       input int wid, input int eoe_k);
        int            len;
        logic [AW-1:0] a;
        logic [HW-1:0] h;
        exp_t          e;
        len = int'(AW'(stop - start)) + 1;
        h = {12'(wid), 45'h0123456789A, start, stop};
        for (int k = 0; k < len; k++) begin
            a = start + AW'(k);
            e.data = {12'(wid), a, (eoe_k < 0) ? (k == len - 1) : (k == eoe_k)};
            mem[a] = e.data;
            e.sop  = (k == 0);
            e.eop  = (k == len - 1);
            e.hdr  = h;
            e.stop = stop;
            exp_q.push_back(e);
        end
        hq.push_back(h);
        n_pushed++;
    endtask

    task automatic wait_done(input int budget, input logic rand_ready);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || model_busy) && k < budget) begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready_i = 1'($urandom_range(0, 1));
            k++;
        end
        out_ready_i = 1'b1;
        if (k >= budget) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_done: timed out after %0d cycles, %0d samples pending", k, exp_q.size());
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int base;

    initial begin
        #23;
        chk("rst_valid", 128'(out_valid_o), 128'(0));
        chk("rst_addr", 128'(wvb_rd_addr_o), 128'(0));
        chk("rst_done", 128'(done_ptr_o), 128'(0));
        chk("rst_busy", 128'(busy_o), 128'(0));
        chk("rst_hdr", 128'(out_hdr_o), 128'(0));
        chk("rst_data", 128'({out_data_o, out_sop_o, out_eop_o, err_eoe_o, hdr_rdreq_o}), 128'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: simple 4-sample waveform
        log_q.delete();
        enq(15'h0010, 15'h0013, 1, -1);
        en_i = 1'b1;
        wait_done(200, 1'b0);
        chk("t1_count", 128'(log_q.size()), 128'(4));
        chk("t1_first", 128'(log_q[0]), 128'(28'h0010020));
        chk("t1_last", 128'(log_q[3]), 128'(28'h0010027));
        chk("t1_done", 128'(done_ptr_o), 128'(15'h0014));
        chk("t1_err", 128'(err_eoe_o), 128'(0));

        // 2: address wrap
        log_q.delete();
        enq(15'h7FFE, 15'h0001, 2, -1);
        wait_done(200, 1'b0);
        chk("t2_count", 128'(log_q.size()), 128'(4));
        chk("t2_s1", 128'(log_q[1]), 128'(28'h002FFFE));
        chk("t2_s2", 128'(log_q[2]), 128'(28'h0020000));
        chk("t2_done", 128'(done_ptr_o), 128'(15'h0002));

        // 3: random backpressure over 64 samples
        log_q.delete();
        chk_bubble = 1'b0;
        enq(15'h0100, 15'h013F, 3, -1);
        wait_done(2000, 1'b1);
        chk_bubble = 1'b1;
        chk("t3_count", 128'(log_q.size()), 128'(64));
        chk("t3_done", 128'(done_ptr_o), 128'(15'h0140));

        // 4: three queued headers of lengths 1, 2, 5
        en_i = 1'b0;
        enq(15'h0400, 15'h0400, 4, -1);
        enq(15'h0410, 15'h0411, 5, -1);
        enq(15'h0420, 15'h0424, 6, -1);
        base = n_acc;
        n_sop = 0;
        n_eop = 0;
        en_i = 1'b1;
        wait_done(300, 1'b0);
        chk("t4_samples", 128'(n_acc - base), 128'(8));
        chk("t4_sop", 128'(n_sop), 128'(3));
        chk("t4_eop", 128'(n_eop), 128'(3));
        chk("t4_done", 128'(done_ptr_o), 128'(15'h0425));

        // 5: reset during sample 3 of 10
        base = n_acc;
        enq(15'h0200, 15'h0209, 7, -1);
        for (int k = 0; k < 100 && n_acc < base + 2; k++) begin
            @(posedge clk);
            #1;
        end
        chk("t5_reached_s3", 128'(n_acc - base), 128'(2));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid", 128'(out_valid_o), 128'(0));
        chk("t5_data", 128'({out_data_o, out_sop_o, out_eop_o}), 128'(0));
        chk("t5_hdr", 128'(out_hdr_o), 128'(0));
        chk("t5_addr", 128'(wvb_rd_addr_o), 128'(0));
        chk("t5_done", 128'(done_ptr_o), 128'(0));
        chk("t5_busy", 128'(busy_o), 128'(0));
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        log_q.delete();
        enq(15'h0300, 15'h0302, 8, -1);
        wait_done(200, 1'b0);
        chk("t5_count", 128'(log_q.size()), 128'(3));
        chk("t5_done_after", 128'(done_ptr_o), 128'(15'h0303));

        // 6: eoe flag on sample 2 of 4, then en=0 blocks pops
        log_q.delete();
        enq(15'h0500, 15'h0503, 9, 1);
        wait_done(200, 1'b0);
        chk("t6_count", 128'(log_q.size()), 128'(4));
        chk("t6_err", 128'(err_eoe_o), 128'(1));
        en_i = 1'b0;
        enq(15'h0600, 15'h0601, 10, -1);
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        chk("t6_no_pop_busy", 128'(busy_o), 128'(0));
        chk("t6_no_pop_req", 128'(hdr_rdreq_o), 128'(0));
        chk("t6_pending", 128'(exp_q.size()), 128'(2));
        en_i = 1'b1;
        wait_done(200, 1'b0);
        chk("t6_err_sticky", 128'(err_eoe_o), 128'(1));
        chk("t6_done", 128'(done_ptr_o), 128'(15'h0602));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
